regfile_mp_clr: RTL and testbench
=================================

// Module: regfile_mp_clr
// PURPOSE
//  Parametrised general-purpose register file for the RV32I core with N read ports,
//  one write port, optional write-first bypass and optional hardwired-zero register 0.
//  A built-in clear sequencer zeroes every register after reset or on request, one
//  register per cycle, and reports completion on ready_o.
//  Sits between decode (read addresses) and writeback (write port); the core stalls while ready_o=0.
// PARAMETERS
//  DATA_WIDTH        32  register width in bits
//  REGISTERS_NUMBER  32  number of registers (2..2**ADDR_BUS_WIDTH)
//  ADDR_BUS_WIDTH    5   register address width
//  READ_PORTS        2   number of independent read ports (1..4)
//  BYPASS_EN         1   1: read of the address being written returns write_data_i (write-first)
//  ZERO_REG_EN       1   1: register 0 reads 0 and ignores writes
// PORTS
//  clk_i          in   1                          clock, rising edge
//  reset_i        in   1                          asynchronous, active-high reset
//  clear_i        in   1                          request to rerun the clear sequence (sampled when ready_o=1)
//  ready_o        out  1                          1 = file usable; 0 = clear in progress
//  write_en_i     in   1                          write strobe
//  write_addr_i   in   ADDR_BUS_WIDTH             write address
//  write_data_i   in   DATA_WIDTH                 write data
//  read_addr_i    in   READ_PORTS*ADDR_BUS_WIDTH  packed read addresses, port k at [k*AW +: AW]
//  read_data_o    out  READ_PORTS*DATA_WIDTH      packed read data, port k at [k*DW +: DW]
// BEHAVIOUR
//  - FSM states: CLEAR, READY. Clear index clr_cnt is ADDR_BUS_WIDTH bits wide.
//  - reset_i=1 (async): state<=CLEAR, clr_cnt<=0, ready_o=0 immediately. Array contents are not reset asynchronously.
//  - CLEAR: each clock, GPR[clr_cnt]<=0 and clr_cnt++.
//    On the edge that writes REGISTERS_NUMBER-1: state<=READY, clr_cnt<=0.
//    ready_o rises exactly REGISTERS_NUMBER edges after reset_i deasserts.
//  - READY, clear_i=1: state<=CLEAR on the next edge. A write in that same cycle is committed and then zeroed by the sequence.
//  - clear_i is ignored while in CLEAR; the sequence is not restarted.
//  - reset_i asserted mid-clear: the sequence aborts and restarts from index 0 after release.
//  - Writes: in READY, write_en_i=1 stores write_data_i at write_addr_i on the rising edge.
//    Writes to address 0 are dropped when ZERO_REG_EN=1.
//    Writes to addresses >= REGISTERS_NUMBER are dropped.
//    In CLEAR, write_en_i is ignored.
//  - Reads: combinational, zero latency, per port k.
//    read_data_o[k]=0 if ready_o=0.
//    Else 0 if ZERO_REG_EN and addr=0.
//    Else 0 if addr >= REGISTERS_NUMBER.
//    Else, if BYPASS_EN and write_en_i and addr==write_addr_i and the write is not dropped: write_data_i.
//    Else GPR[addr].
//  - Multiple ports reading the same address return identical data.
//  - BYPASS_EN=0: a same-cycle read returns the old value; the new value is visible from the next cycle.
//  - Outputs during and after reset: ready_o=0; all read_data_o=0 until ready_o=1.
// TESTING
//  1 Release reset (default params) -> ready_o=0 for 32 edges, then 1; every port reads 0 for addresses 0..31.
//  2 Write x5=0xDEADBEEF, read port0=x5 and port1=x5 in the same cycle -> both return 0xDEADBEEF (bypass).
//    With BYPASS_EN=0, both return 0 that cycle and 0xDEADBEEF the next.
//  3 Write x0=0x12345678 -> x0 reads 0 on all ports, same cycle and later; no other register changes.
//  4 Fill x1..x31 with nonzero data, pulse clear_i -> ready_o=0 for 32 cycles; writes issued during clear are ignored;
//    after ready_o=1 all registers read 0.
//  5 Assert reset_i async mid-clear at clr_cnt=10 -> ready_o stays 0; after release, exactly 32 more edges before ready_o=1.
//  6 READ_PORTS=4, REGISTERS_NUMBER=16: write x3=0xA5, read ports at {3,0,15,20} -> {0xA5,0,GPR[15],0};
//    write to x20 has no effect.

Source files
------------

// File: rtl/regfile_mp_clr_if.sv
// Bus bundle for the multi-port register file: writeback write port, decode read ports,
// and the clear/ready handshake.
interface regfile_mp_clr_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_BUS_WIDTH = 5,
    parameter int READ_PORTS     = 2
) ();
    logic                                 clear_i;
    logic                                 ready_o;
    logic                                 write_en_i;
    logic [ADDR_BUS_WIDTH-1:0]            write_addr_i;
    logic [DATA_WIDTH-1:0]                write_data_i;
    logic [READ_PORTS*ADDR_BUS_WIDTH-1:0] read_addr_i;
    logic [READ_PORTS*DATA_WIDTH-1:0]     read_data_o;

    modport slave (
        input  clear_i, write_en_i, write_addr_i, write_data_i, read_addr_i,
        output ready_o, read_data_o
    );

    modport master (
        output clear_i, write_en_i, write_addr_i, write_data_i, read_addr_i,
        input  ready_o, read_data_o
    );
endinterface

// File: rtl/regfile_mp_clr.sv
// RV32I general-purpose register file: N combinational read ports, one write port,
// optional write-first bypass and hardwired x0, with a one-register-per-cycle clear sequencer.
module regfile_mp_clr #(
    parameter int DATA_WIDTH       = 32,
    parameter int REGISTERS_NUMBER = 32,
    parameter int ADDR_BUS_WIDTH   = 5,
    parameter int READ_PORTS       = 2,
    parameter int BYPASS_EN        = 1,
    parameter int ZERO_REG_EN      = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    regfile_mp_clr_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_BUS_WIDTH;
    localparam logic [ADDR_BUS_WIDTH:0]   REG_NUM  = (ADDR_BUS_WIDTH + 1)'(REGISTERS_NUMBER);
    localparam logic [ADDR_BUS_WIDTH-1:0] LAST_IDX = ADDR_BUS_WIDTH'(REGISTERS_NUMBER - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                           state_q;
    logic [ADDR_BUS_WIDTH-1:0]        clr_cnt_q;
    logic                             ready_q;
    logic [DATA_WIDTH-1:0]            gpr_q [DEPTH];
    logic                             write_ok_s;
    logic [READ_PORTS*DATA_WIDTH-1:0] rdata_d;

    // An address is live when it names an implemented register other than a hardwired x0.
    function automatic logic addr_live(input logic [ADDR_BUS_WIDTH-1:0] addr);
        return ({1'b0, addr} < REG_NUM) && !((ZERO_REG_EN != 0) && (addr == '0));
    endfunction

    assign write_ok_s      = ready_q && bus.write_en_i && addr_live(bus.write_addr_i);
    assign bus.ready_o     = ready_q;
    assign bus.read_data_o = rdata_d;

    // Clear/ready sequencer; ready_q is the registered copy of the READY state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q   <= ST_READY;
                        clr_cnt_q <= '0;
                        ready_q   <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_BUS_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (bus.clear_i) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sequencer owns the array while clearing, writeback owns it when ready.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            gpr_q[clr_cnt_q] <= '0;
        end else if (write_ok_s) begin
            gpr_q[bus.write_addr_i] <= bus.write_data_i;
        end
    end

    // Zero-latency read ports with optional write-first forwarding.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            if (!ready_q || !addr_live(bus.read_addr_i[k*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH])) begin
                rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS_EN != 0) && write_ok_s &&
                         (bus.read_addr_i[k*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH] == bus.write_addr_i)) begin
                rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.write_data_i;
            end else begin
                rdata_d[k*DATA_WIDTH +: DATA_WIDTH] =
                    gpr_q[bus.read_addr_i[k*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH]];
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp_clr.sv
// Bench for regfile_mp_clr: default instance against a behavioural model, plus a
// 4-port/16-register/no-bypass instance driven by hand-written sequences.
module tb_regfile_mp_clr;
    logic clk;
    logic reset_i;
    int   n_checks;
    int   n_errors;

    regfile_mp_clr_if #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(5), .READ_PORTS(2)) a_if ();
    regfile_mp_clr_if #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(5), .READ_PORTS(4)) b_if ();

    regfile_mp_clr dut_a (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (a_if)
    );

    regfile_mp_clr #(
        .DATA_WIDTH(32), .REGISTERS_NUMBER(16), .ADDR_BUS_WIDTH(5),
        .READ_PORTS(4), .BYPASS_EN(0), .ZERO_REG_EN(1)
    ) dut_b (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the default instance: 32 registers, ready flag, edges left in a clear.
    logic [31:0] m_gpr [32];
    logic        m_ready;
    int          m_left;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (!m_ready || a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_gpr[a];
    endfunction

    task automatic model_edge(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic clr);
        if (m_ready) begin
            if (we && wa != 5'd0) m_gpr[wa] = wd;
            if (clr) begin
                m_ready = 1'b0;
                m_left  = 32;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            end
        end
    endtask

    // One cycle on the default instance: drive, check reads against the model, clock.
    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic clr, input logic [4:0] r0, input logic [4:0] r1,
                       output logic [31:0] s0, output logic [31:0] s1);
        a_if.write_en_i   = we;
        a_if.write_addr_i = wa;
        a_if.write_data_i = wd;
        a_if.clear_i      = clr;
        a_if.read_addr_i  = {r1, r0};
        #1;
        s0 = a_if.read_data_o[31:0];
        s1 = a_if.read_data_o[63:32];
        chk("a_ready", {31'd0, a_if.ready_o}, {31'd0, m_ready});
        chk("a_rd0", s0, m_read(r0, we, wa, wd));
        chk("a_rd1", s1, m_read(r1, we, wa, wd));
        @(posedge clk);
        model_edge(we, wa, wd, clr);
        #1;
    endtask

    task automatic set_b(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [19:0] ra);
        b_if.write_en_i   = we;
        b_if.write_addr_i = wa;
        b_if.write_data_i = wd;
        b_if.read_addr_i  = ra;
        #1;
    endtask

    task automatic chk_b(input string name, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
        chk({name, "_p0"}, b_if.read_data_o[31:0],   e0);
        chk({name, "_p1"}, b_if.read_data_o[63:32],  e1);
        chk({name, "_p2"}, b_if.read_data_o[95:64],  e2);
        chk({name, "_p3"}, b_if.read_data_o[127:96], e3);
    endtask

    initial begin
        logic [31:0] s0;
        logic [31:0] s1;
        int          n;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'h1,        5'd31, 5'd30, 32'h1,        32'h0};
        vecs[5] = '{1'b1, 5'd30, 32'hCAFE,     5'd31, 5'd30, 32'h1,        32'hCAFE};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd31, 32'hCAFE,     32'h1};

        reset_i = 1'b1;
        a_if.clear_i = 1'b0; a_if.write_en_i = 1'b0; a_if.write_addr_i = 5'd0;
        a_if.write_data_i = 32'd0; a_if.read_addr_i = {5'd5, 5'd1};
        b_if.clear_i = 1'b0; b_if.write_en_i = 1'b0; b_if.write_addr_i = 5'd0;
        b_if.write_data_i = 32'd0; b_if.read_addr_i = 20'd0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_ready = 1'b0;
        m_left  = 32;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, a_if.ready_o}, 32'd0);
        chk("reset_rdata", a_if.read_data_o[31:0] | a_if.read_data_o[63:32], 32'd0);
        reset_i = 1'b0;

        // ready_o must rise on exactly the 32nd edge (16th for the small instance).
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            chk("a_ready_edge", {31'd0, a_if.ready_o}, {31'd0, (i == 32)});
            if (i == 15 || i == 16)
                chk("b_ready_edge", {31'd0, b_if.ready_o}, {31'd0, (i == 16)});
        end
        m_ready = 1'b1;

        for (int a = 0; a < 32; a += 2) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(a + 1), s0, s1);

        for (int v = 0; v < 7; v++) begin
            cyc(vecs[v].we, vecs[v].wa, vecs[v].wd, 1'b0, vecs[v].r0, vecs[v].r1, s0, s1);
            chk("vec_rd0", s0, vecs[v].e0);
            chk("vec_rd1", s1, vecs[v].e1);
        end

        for (int a = 1; a < 32; a++)
            cyc(1'b1, 5'(a), $urandom | 32'h1, 1'b0, 5'(a), 5'($urandom_range(0, 31)), s0, s1);
        cyc(1'b1, 5'd7, 32'h0BADF00D, 1'b1, 5'd7, 5'd8, s0, s1);
        for (int i = 0; i < 32; i++)
            cyc(1'b1, 5'($urandom_range(1, 31)), $urandom, (i == 5), 5'(i), 5'd7, s0, s1);
        chk("clear_done", {31'd0, a_if.ready_o}, 32'd1);
        for (int a = 0; a < 32; a += 2) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(a + 1), s0, s1);
        for (int a = 1; a < 32; a++) cyc(1'b1, 5'(a), $urandom | 32'h1, 1'b0, 5'd0, 5'd0, s0, s1);

        // Reset arrives asynchronously with clr_cnt at 10; the clear must start over.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2, s0, s1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd20, s0, s1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("midclr_ready", {31'd0, a_if.ready_o}, 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        n = 0;
        while (!a_if.ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midclr_edges", n, 32'd32);
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        for (int a = 0; a < 32; a += 2) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(a + 1), s0, s1);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 5'($urandom), $urandom, $urandom_range(0, 49) == 0,
                5'($urandom), 5'($urandom), s0, s1);

        // Small instance: no bypass, 16 registers, out-of-range addresses read 0.
        set_b(1'b1, 5'd3, 32'hA5, {5'd20, 5'd15, 5'd0, 5'd3});
        chk_b("b_wr3_same", 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        set_b(1'b0, 5'd0, 32'h0, {5'd20, 5'd15, 5'd0, 5'd3});
        chk_b("b_wr3_next", 32'hA5, 32'h0, 32'h0, 32'h0);
        set_b(1'b1, 5'd20, 32'h77, {5'd3, 5'd4, 5'd20, 5'd20});
        @(posedge clk); #1;
        set_b(1'b1, 5'd15, 32'h1515, {5'd3, 5'd15, 5'd4, 5'd20});
        chk_b("b_wr15_same", 32'h0, 32'h0, 32'h0, 32'hA5);
        @(posedge clk); #1;
        set_b(1'b1, 5'd0, 32'h99, {5'd0, 5'd3, 5'd15, 5'd15});
        chk_b("b_wr15_next", 32'h1515, 32'h1515, 32'hA5, 32'h0);
        @(posedge clk); #1;
        set_b(1'b0, 5'd0, 32'h0, {5'd20, 5'd4, 5'd0, 5'd0});
        chk_b("b_x0_x20", 32'h0, 32'h0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
